// File: rtl/nanorv32_irq_pkg.sv
// nanorv32_irq_pkg: shared FSM encoding, default sizing and chip source indices for the interrupt controller
package nanorv32_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_REQ    = 2'd1,
    IRQ_ACTIVE = 2'd2
  } irq_state_t;

  localparam int NB_IRQ_DEFAULT = 8;

  localparam int IRQ_UART = 0;
  localparam int IRQ_GPIO = 1;

endpackage

// File: rtl/nanorv32_irq_prio_enc.sv
// nanorv32_irq_prio_enc: fixed-priority encoder, lowest set bit of vec wins
module nanorv32_irq_prio_enc #(
  parameter int NB_IRQ = 8,
  parameter int IDW    = 3
) (
  input  logic [NB_IRQ-1:0] vec,
  output logic [IDW-1:0]    sel,
  output logic              any
);

  // scan from the top down so the lowest index is written last and wins
  always_comb begin
    sel = '0;
    any = |vec;
    for (int i = NB_IRQ - 1; i >= 0; i--)
      if (vec[i]) sel = IDW'(i);
  end

endmodule

// File: rtl/nanorv32_irq_ctrl.sv
// nanorv32_irq_ctrl: edge/level interrupt latch, mask, fixed priority and req/ack/done handshake to the core
// Optional input synchroniser on irq_src enabled by defining NANORV32_IRQ_SYNC_EN.
module nanorv32_irq_ctrl
  import nanorv32_irq_pkg::*;
#(
  parameter int NB_IRQ = NB_IRQ_DEFAULT,
  parameter int IDW    = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NB_IRQ-1:0] irq_src,
  input  logic [NB_IRQ-1:0] irq_en,
  input  logic [NB_IRQ-1:0] irq_edge,
  input  logic              irq_ack,
  input  logic              irq_done,
  output logic              irq_req,
  output logic [IDW-1:0]    irq_id,
  output logic              irq_active,
  output logic [NB_IRQ-1:0] irq_pending
);

  irq_state_t        state, state_nx;
  logic [NB_IRQ-1:0] src_in, src_q, rise, edge_pend, clr, eligible;
  logic [IDW-1:0]    sel;
  logic              any, take_ack;

`ifdef NANORV32_IRQ_SYNC_EN
  logic [NB_IRQ-1:0] sync1, sync2;

  // two-flop synchroniser for sources that are asynchronous to clk_in
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src_in = sync2;
`else
  assign src_in = irq_src;
`endif

  assign rise        = src_in & ~src_q;
  assign take_ack    = (state == IRQ_REQ) && irq_ack;
  assign clr         = take_ack ? (NB_IRQ'(1) << irq_id) : '0;
  assign irq_pending = (edge_pend & irq_edge) | (src_q & ~irq_edge);
  assign eligible    = irq_pending & irq_en;

  nanorv32_irq_prio_enc #(
    .NB_IRQ(NB_IRQ),
    .IDW   (IDW)
  ) u_prio (
    .vec(eligible),
    .sel(sel),
    .any(any)
  );

  // source history and edge-mode pending latch; a new edge beats a same-cycle ack clear
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      src_q     <= '0;
      edge_pend <= '0;
    end else begin
      src_q     <= src_in;
      edge_pend <= irq_edge & (rise | (edge_pend & ~clr));
    end
  end

  // state register and the id captured when a request is launched
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state  <= IRQ_IDLE;
      irq_id <= '0;
    end else begin
      state <= state_nx;
      if (state == IRQ_IDLE && any) irq_id <= sel;
    end
  end

  // next state: ack beats withdrawal; no preemption while requesting or in service
  always_comb begin
    state_nx = state;
    case (state)
      IRQ_IDLE:   state_nx = any ? IRQ_REQ : IRQ_IDLE;
      IRQ_REQ:    state_nx = irq_ack ? IRQ_ACTIVE : (eligible[irq_id] ? IRQ_REQ : IRQ_IDLE);
      IRQ_ACTIVE: state_nx = irq_done ? IRQ_IDLE : IRQ_ACTIVE;
      default:    state_nx = IRQ_IDLE;
    endcase
  end

  // handshake outputs decoded from the registered state
  always_comb begin
    irq_req    = (state == IRQ_REQ);
    irq_active = (state == IRQ_ACTIVE);
  end

endmodule
